firebird7_in_gate1_tessent_data_mux_ctrl_w3: RTL
================================================

// Module: firebird7_in_gate1_tessent_data_mux_ctrl_w3
//
// PURPOSE
//  IJTAG test data register (TDR) plus override sequencer for a WIDTH-bit functional/IJTAG data mux.
//  Holds the override data and an enable bit, loaded through the IJTAG scan path.
//  Drives the mux ijtag_select with a settle window: data is stable SETTLE_CYCLES before select rises,
//  and select is low SETTLE_CYCLES before the next override can start.
//  Sits in the gate1 IJTAG network next to the data mux and is selected via the upstream SIB.
//
// PARAMETERS
//  WIDTH          3   width of the mux data path; TDR length is WIDTH+1
//  SETTLE_CYCLES  2   ARM/RELEASE dwell in ijtag_tck cycles; legal 1..15; counter is 4 bits
//
// PORTS
//  ijtag_tck           in   1      IJTAG clock; the only clock
//  ijtag_reset         in   1      synchronous, active-high reset
//  ijtag_sel           in   1      this TDR is selected on the scan path
//  ijtag_ce            in   1      capture enable
//  ijtag_se            in   1      shift enable
//  ijtag_ue            in   1      update enable
//  ijtag_si            in   1      scan in
//  ijtag_so            out  1      scan out = sr[0] (combinational from the register)
//  functional_data_in  in   WIDTH  functional mux input; captured for observation
//  mux_ijtag_data      out  WIDTH  registered override data to the mux ijtag_data_in
//  mux_ijtag_select    out  1      registered mux select
//  override_active     out  1      high in state ACTIVE only (equals mux_ijtag_select)
//
// BEHAVIOUR
//  Reset: sr, upd_en, upd_data and cnt clear to 0; state goes to IDLE.
//   All outputs are 0 from the first edge with ijtag_reset=1. Reset mid-override drops select on that edge.
//  TDR: sr[WIDTH:0] = {en, data[WIDTH-1:0]}. sr acts only when ijtag_sel=1.
//   Priority is ce > se > ue; all are ignored when ijtag_sel=0.
//  Capture: sr <= {mux_ijtag_select, functional_data_in}.
//  Shift: sr <= {ijtag_si, sr[WIDTH:1]}. LSB exits first on ijtag_so.
//  Update: upd_en <= sr[WIDTH]; upd_data <= sr[WIDTH-1:0].
//   mux_ijtag_data = upd_data, so it changes one cycle after ue.
//   Update is allowed in any FSM state. A data-only change while ACTIVE passes straight to the mux.
//  FSM (evaluated every cycle using the registered upd_en):
//   IDLE:    select=0. If upd_en=1: cnt<=0, go to ARM.
//   ARM:     select=0, cnt++.
//            If upd_en=0: go to IDLE (abort).
//            Else if cnt==SETTLE_CYCLES-1: go to ACTIVE.
//   ACTIVE:  select=1. If upd_en=0: cnt<=0, go to RELEASE.
//   RELEASE: select=0, cnt++. If cnt==SETTLE_CYCLES-1: go to IDLE. upd_en is ignored here.
//            A re-enable is honoured from IDLE on the next cycle.
//  Latency: with SETTLE_CYCLES=S, select rises S+1 cycles after the upd_en edge
//   (1 cycle IDLE to ARM, then S cycles in ARM).
//   Select falls 1 cycle after the upd_en falling edge.
//  mux_ijtag_select is a register output decoded from next-state, so it is glitch-free.
//  cnt saturates and never wraps; it is reset on every ARM/RELEASE entry.
//  Simultaneous ce+ue: capture wins and no update occurs.
//  ue with ijtag_sel=0 is ignored.
//
// TESTING
//  1. Reset with all inputs X->0 -> all outputs 0, state IDLE; ijtag_so=0 after 4 shifts of si=0.
//  2. Shift in 4'b1101 (en=1, data=3'b101), then ue -> mux_ijtag_data=3'b101 one cycle later;
//     mux_ijtag_select=1 exactly 3 cycles after the upd_en edge (S=2); override_active=1.
//  3. While ACTIVE, shift and update 4'b0101 -> select=0 the next cycle; RELEASE lasts 2 cycles;
//     data stays 3'b101.
//  4. Re-enable (4'b1011) during RELEASE -> select stays 0 through RELEASE and ARM;
//     rises S+1 cycles after re-entering IDLE.
//  5. functional_data_in=3'b110 in IDLE, then capture and shift 4 bits -> so sequence 0,1,1,0 (LSB first).
//  6. ijtag_reset for 1 cycle while ACTIVE -> select=0 and data=0 on that edge;
//     ce/se/ue with ijtag_sel=0 leave sr unchanged.

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w3.sv
// IJTAG test data register plus override sequencer for the gate1 data mux.
// The TDR holds {enable, data}. A four-state sequencer raises the mux select
// only after the override data has been stable for SETTLE_CYCLES. After select
// drops, it holds off any new override for another SETTLE_CYCLES.
module firebird7_in_gate1_tessent_data_mux_ctrl_w3 #(
  parameter int WIDTH         = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] functional_data_in,
  output logic [WIDTH-1:0] mux_ijtag_data,
  output logic             mux_ijtag_select,
  output logic             override_active
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_ACTIVE,
    ST_RELEASE
  } state_e;

  // Last count value of an ARM or RELEASE dwell. The counter is 4 bits, so
  // SETTLE_CYCLES is limited to 1..15.
  localparam logic [3:0] LP_CNT_LAST = 4'(SETTLE_CYCLES - 1);

  logic [WIDTH:0]   r_sr;
  logic             r_upd_en;
  logic [WIDTH-1:0] r_upd_data;
  logic [3:0]       r_cnt;
  state_e           r_state;
  logic             r_select;

  state_e           w_state_nxt;
  logic [3:0]       w_cnt_nxt;
  logic [3:0]       w_cnt_inc;
  logic             w_select_nxt;

  // Scan register: when selected, capture has priority over shift, and shift over update.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      r_sr <= '0;
    end else if (ijtag_sel) begin
      if (ijtag_ce) begin
        r_sr <= {r_select, functional_data_in};
      end else if (ijtag_se) begin
        r_sr <= {ijtag_si, r_sr[WIDTH:1]};
      end
    end
  end

  // Update stage: copies the TDR into the shadow registers that drive the mux and sequencer.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      r_upd_en   <= 1'b0;
      r_upd_data <= '0;
    end else if (ijtag_sel && !ijtag_ce && !ijtag_se && ijtag_ue) begin
      r_upd_en   <= r_sr[WIDTH];
      r_upd_data <= r_sr[WIDTH-1:0];
    end
  end

  // Sequencer registers. The select bit is registered from the next state so the mux never sees a glitch.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_select <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_select <= w_select_nxt;
    end
  end

  // Dwell counter increment that saturates at its maximum instead of wrapping.
  assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

  // Next-state, counter and select decode for the override sequencer.
  // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_select_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_upd_en) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_ARM;
        end
      end
      ST_ARM: begin
        w_cnt_nxt = w_cnt_inc;
        if (!r_upd_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (!r_upd_en) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // The enable bit is ignored here. A re-enable is honoured once back in IDLE.
        w_cnt_nxt = w_cnt_inc;
        if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_select_nxt = (w_state_nxt == ST_ACTIVE);
  end

  assign ijtag_so         = r_sr[0];
  assign mux_ijtag_data   = r_upd_data;
  assign mux_ijtag_select = r_select;
  assign override_active  = r_select;

endmodule
